// File: rtl/mips_multicycle_control.sv
// ----------------------------------------------------------------------------
// mips_multicycle_control
//
// Main control FSM for the multicycle MIPS datapath. It steps each instruction
// through fetch, decode, execute, memory and writeback. It drives every
// datapath mux select and write enable, and it produces the 2-bit ALUOp for
// the downstream ALU control decoder. Supported instructions are lw, sw,
// R-type, beq, j and addi. Memory accesses stall on the MemReady handshake.
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   Op[5:0]      in   opcode IR[31:26], valid from DECODE onward
//   MemReady     in   memory completes the current access this cycle
//   PCWrite      out  unconditional PC load
//   PCWriteCond  out  PC load if ALU Zero
//   IorD         out  memory address select (0 = PC, 1 = ALUOut)
//   MemRead      out  memory read request
//   MemWrite     out  memory write request
//   IRWrite      out  instruction register load
//   MemtoReg     out  register write data (0 = ALUOut, 1 = MDR)
//   RegDst       out  destination register (0 = rt, 1 = rd)
//   RegWrite     out  register file write enable
//   ALUSrcA      out  ALU A input (0 = PC, 1 = register A)
//   ALUSrcB[1:0] out  ALU B input (B, 4, imm, imm<<2)
//   ALUOp[1:0]   out  00 = add, 01 = subtract, 10 = decode by funct
//   PCSource[1:0]out  00 = ALU result, 01 = ALUOut, 10 = jump target
//   IllegalOp    out  one-cycle pulse in DECODE on an unsupported opcode
//   State[3:0]   out  current state, for debug
// ----------------------------------------------------------------------------
module mips_multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] Op,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       IllegalOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    state_t     r_state;
    logic [5:0] r_op;
    logic       w_opSupported;

    // The opcode is only checked against the supported set while in DECODE.
    // Every later decision uses the copy latched on the DECODE edge.
    assign w_opSupported = (Op == OP_RTYPE) || (Op == OP_LW)  || (Op == OP_SW) ||
                           (Op == OP_BEQ)   || (Op == OP_J)   || (Op == OP_ADDI);

    assign State = r_state;

    // State register and next-state logic. The three memory-facing states
    // (FETCH, MEMRD, MEMWR) hold until MemReady. All other states advance
    // unconditionally. The unused codes 13-15 fall back to FETCH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_RESET;
            r_op    <= '0;
        end else begin
            case (r_state)
                S_RESET:  r_state <= S_FETCH;
                S_FETCH:  if (MemReady) r_state <= S_DECODE;
                S_DECODE: begin
                    r_op <= Op;
                    if ((Op == OP_LW) || (Op == OP_SW)) r_state <= S_MEMADR;
                    else if (Op == OP_RTYPE)            r_state <= S_EXEC;
                    else if (Op == OP_BEQ)              r_state <= S_BRANCH;
                    else if (Op == OP_J)                r_state <= S_JUMP;
                    else if (Op == OP_ADDI)             r_state <= S_ADDIEX;
                    else                                r_state <= S_FETCH;
                end
                S_MEMADR: r_state <= (r_op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (MemReady) r_state <= S_MEMWB;
                S_MEMWB:  r_state <= S_FETCH;
                S_MEMWR:  if (MemReady) r_state <= S_FETCH;
                S_EXEC:   r_state <= S_RWB;
                S_RWB:    r_state <= S_FETCH;
                S_BRANCH: r_state <= S_FETCH;
                S_JUMP:   r_state <= S_FETCH;
                S_ADDIEX: r_state <= S_ADDIWB;
                S_ADDIWB: r_state <= S_FETCH;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Moore-style output decode from the current state. Reset drops the state
    // to RESET asynchronously, so every enable falls in the same cycle. The
    // FETCH enables follow MemReady combinationally, so the PC and IR load
    // only on the cycle the instruction word actually arrives.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        IllegalOp   = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_DECODE: begin
                ALUSrcB   = 2'b11;
                IllegalOp = !w_opSupported;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath. It sits directly upstream of the ALU control decoder and drives its 2-bit ALUOp.
- Sequences each instruction through fetch/decode/execute/memory/writeback and emits every datapath mux select and write enable.
- Supports lw, sw, R-type, beq, j and addi, and stalls on a memory-ready handshake.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_J, 6'b000010, jump opcode
- OP_ADDI, 6'b001000, add-immediate opcode

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- Op  input  6  opcode field IR[31:26]; valid from DECODE onward
- MemReady  input  1  memory completes the current read/write this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if ALU Zero
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  instruction register load
- MemtoReg  output  1  register write data: 0 = ALUOut, 1 = MDR
- RegDst  output  1  destination register: 0 = rt, 1 = rd
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  ALU A input: 0 = PC, 1 = register A
- ALUSrcB  output  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- ALUOp  output  2  to the ALU control decoder: 00 = add, 01 = subtract, 10 = decode by funct
- PCSource  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- IllegalOp  output  1  one-cycle pulse on an unsupported opcode
- State  output  4  current state, for debug

Behaviour:
- Asynchronous reset: reset_n=0 forces state RESET (0) immediately. All outputs are 0 while in RESET.
- The first rising edge after release moves RESET to FETCH.
- State encoding: RESET=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12. Codes 13-15 are unreachable and return to FETCH.
- Outputs are decoded from the current state. Any output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=MemReady, gated combinationally, so the PC never advances while stalled.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes the branch target).
  - Op is latched into an internal register on the DECODE edge. All later decisions use the latched opcode, so changes on Op after DECODE are ignored.
  - Next state: lw/sw -> MEMADR, R-type -> EXEC, beq -> BRANCH, j -> JUMP, addi -> ADDIEX.
  - Any other opcode: IllegalOp=1 for the DECODE cycle only, then FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: MemRead=1, IorD=1. Stays while MemReady=0; goes to MEMWB when MemReady=1.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next: FETCH.
- MEMWR: MemWrite=1, IorD=1. Stays while MemReady=0; goes to FETCH when MemReady=1.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next: FETCH.
- JUMP: PCWrite=1, PCSource=10. Next: FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Next: FETCH.
- Latency with MemReady held at 1, counting FETCH cycles through the last state:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.
  - Each stalled cycle (MemReady=0 in FETCH, MEMRD or MEMWR) adds one cycle.
- Reset mid-instruction, including during a stall: returns to RESET immediately.
  - MemWrite and RegWrite drop in the same cycle. No partial write is committed by this block.
- MemReady is ignored in every state other than FETCH, MEMRD and MEMWR.
- The one-hot invariants hold in all states: MemRead and MemWrite are never both 1, and RegWrite and MemWrite are never both 1.

Test Plan:
- Reset, then MemReady=1 and Op=100011 (lw) -> State sequence 0,1,2,3,4,5,1. RegWrite=1 and MemtoReg=1 only in state 5. PCWrite=1 only in the single FETCH cycle.
- Op=000000 (R-type) -> ALUOp=10 in EXEC, RegWrite=1 and RegDst=1 in RWB, back to FETCH after 4 cycles. Op=000100 (beq) -> ALUOp=01, PCWriteCond=1, PCSource=01 in BRANCH, 3 cycles.
- sw with MemReady=0 for 3 cycles in MEMWR -> MemWrite=1 held for 4 cycles and State stays 6; goes to FETCH the cycle after MemReady=1.
- MemReady=0 for 2 cycles in FETCH -> PCWrite=0 and IRWrite=0 while stalled. Exactly one PCWrite pulse when MemReady=1.
- Op=111111 -> IllegalOp=1 for exactly one cycle in DECODE, then State=1. Op changed from 001000 to 000000 after DECODE -> the addi path (ADDIEX, ADDIWB, RegDst=0) is still taken.
- reset_n low in MEMWR while stalled -> State=0 and all outputs 0 asynchronously, before the next clock edge. After release, the next state is FETCH.
